fpmult_share_sched: RTL

// - Shares one fixed-latency FP multiplier datapath (prep/partial-product -> multiply -> normalise) among NUM_REQ requesters.
// - Round-robin arbiter issues at most one operand pair per cycle into the multiplier.
// - A tag pipeline returns each product, with its requester ID, after a fixed latency.
// - Sits between the requesting PEs/accumulators and the FPMult pipeline; the multiplier itself is untouched.

---
 rtl/fpmult_share_sched_pkg.sv | 16 +
 rtl/fpmult_share_sched_rr_arbiter.sv | 39 +++
 rtl/fpmult_share_sched.sv | 109 ++++++++++
 3 files changed

// File: rtl/fpmult_share_sched_pkg.sv
// Shared FP word definitions and helpers for the multiplier-sharing scheduler.
// DWIDTH/EXPONENT/MANTISSA describe the IEEE single-precision word that the FPMult pipe consumes.
package fpmult_share_sched_pkg;

    localparam int DWIDTH         = 32;
    localparam int EXPONENT       = 8;
    localparam int MANTISSA       = 23;
    localparam int EXC_W          = 5;
    localparam int FPMULT_LATENCY = 4;

    // Round-robin successor of a requester index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fpmult_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found at or after i_ptr
// (wrapping modulo NUM_REQ) gets a one-hot grant.
module fpmult_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_any_grant
);

    int  w_sel;
    int  w_pos;
    logic w_hit;

    // Offsets are walked from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        w_sel = 0;
        w_pos = 0;
        w_hit = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_pos == i && i_req[i]) begin
                    w_sel = i;
                    w_hit = 1'b1;
                end
            end
        end
    end

    assign o_any_grant = w_hit;
    assign o_grant     = w_hit ? (NUM_REQ'(1) << w_sel) : '0;
    assign o_grant_id  = ID_W'(w_sel);

endmodule

// File: rtl/fpmult_share_sched.sv
// Shares one fixed-latency FP multiplier among NUM_REQ requesters: round-robin issue,
// a tag pipe that tracks the owner of each in-flight product, and registered results.
module fpmult_share_sched
    import fpmult_share_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = FPMULT_LATENCY,
    parameter int DW      = DWIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_en,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  mul_valid,
    output logic [DW-1:0]         mul_a,
    output logic [DW-1:0]         mul_b,
    input  logic [DW-1:0]         mul_result,
    input  logic [EXC_W-1:0]      mul_exc,
    output logic                  res_valid,
    output logic [ID_W-1:0]       res_id,
    output logic [DW-1:0]         res_data,
    output logic [EXC_W-1:0]      res_exc,
    output logic                  busy
);

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_any_grant;
    logic [DW-1:0]      w_op_a [NUM_REQ];
    logic [DW-1:0]      w_op_b [NUM_REQ];

    logic [ID_W-1:0]    r_rr_ptr;
    logic [DW-1:0]      r_mul_a;
    logic [DW-1:0]      r_mul_b;
    // Stage 0 is loaded alongside the operand registers; stage LATENCY lines up with mul_result.
    logic [LATENCY:0]   r_tag_valid;
    logic [ID_W-1:0]    r_tag_id [LATENCY+1];
    logic               r_res_valid;
    logic [ID_W-1:0]    r_res_id;
    logic [DW-1:0]      r_res_data;
    logic [EXC_W-1:0]   r_res_exc;

    // Holding reset also blocks grants so no handshake is seen while state is cleared.
    assign w_req = req_valid & {NUM_REQ{issue_en & rst}};

    fpmult_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req       (w_req),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id),
        .o_any_grant (w_any_grant)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_op_a[gi] = req_a[gi*DW +: DW];
            assign w_op_b[gi] = req_b[gi*DW +: DW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr    <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_tag_valid <= '0;
            for (int k = 0; k <= LATENCY; k++) r_tag_id[k] <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
            r_res_exc   <= '0;
        end else begin
            r_tag_valid <= {r_tag_valid[LATENCY-1:0], w_any_grant};
            r_tag_id[0] <= w_grant_id;
            for (int k = 1; k <= LATENCY; k++) r_tag_id[k] <= r_tag_id[k-1];
            if (w_any_grant) begin
                r_mul_a  <= w_op_a[w_grant_id];
                r_mul_b  <= w_op_b[w_grant_id];
                r_rr_ptr <= ID_W'(rr_next(int'(w_grant_id), NUM_REQ));
            end
            r_res_valid <= r_tag_valid[LATENCY];
            if (r_tag_valid[LATENCY]) begin
                r_res_id   <= r_tag_id[LATENCY];
                r_res_data <= mul_result;
                r_res_exc  <= mul_exc;
            end
        end
    end

    assign req_ready = w_grant;
    assign mul_valid = r_tag_valid[0];
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_data  = r_res_data;
    assign res_exc   = r_res_exc;
    assign busy      = (|r_tag_valid) | r_res_valid;

endmodule
